// File: rtl/pool_flat_engine.sv
// 2x2 max-pool over two 64x64 conv kernels with a combined flatten write.
// Each pooled word goes to its own pool bank and is also interleaved into the flat bank.
module pool_flat_engine #(
  parameter int DATA_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     crd,
  output logic [11:0]              caddr_rd,
  input  logic signed [DATA_W-1:0] cdata_rd,
  output logic                     cwr,
  output logic [11:0]              caddr_wr,
  output logic [DATA_W-1:0]        cdata_wr,
  output logic [2:0]               csel
);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, CMP, WR_POOL, WR_FLAT, FIN
  } state_t;

  state_t                    state, state_n;
  logic [9:0]                p, p_n;
  logic                      k, k_n;
  logic signed [DATA_W-1:0]  run_max, max_n;
  logic [11:0]               base_n;

  logic                      busy_n, done_n, crd_n, cwr_n;
  logic [11:0]               caddr_rd_n, caddr_wr_n;
  logic [DATA_W-1:0]         cdata_wr_n;
  logic [2:0]                csel_n;

  // NOTE: every signal gets a default at the top of the block, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    p_n     = p;
    k_n     = k;
    max_n   = run_max;
    case (state)
      IDLE: if (start) begin
        p_n     = '0;
        k_n     = 1'b0;
        state_n = RD0;
      end
      RD0: state_n = RD1;
      RD1: begin
        max_n   = cdata_rd;
        state_n = RD2;
      end
      RD2, RD3, CMP: begin
        // A tie keeps the current maximum.
        if (cdata_rd > run_max) max_n = cdata_rd;
        state_n = (state == RD2) ? RD3 : (state == RD3) ? CMP : WR_POOL;
      end
      WR_POOL: state_n = WR_FLAT;
      WR_FLAT: begin
        if (!k) begin
          k_n     = 1'b1;
          state_n = RD0;
        end else begin
          k_n = 1'b0;
          if (p == 10'd1023) begin
            state_n = FIN;
          end else begin
            p_n     = p + 10'd1;
            state_n = RD0;
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they come straight out of flops,
  // yet still line up with the state they belong to.
  assign base_n = {p_n[9:5], 1'b0, p_n[4:0], 1'b0};

  always_comb begin
    busy_n     = (state_n != IDLE);
    done_n     = 1'b0;
    crd_n      = 1'b0;
    cwr_n      = 1'b0;
    caddr_rd_n = '0;
    caddr_wr_n = '0;
    cdata_wr_n = '0;
    csel_n     = 3'b000;
    case (state_n)
      RD0, RD1, RD2, RD3: begin
        crd_n  = 1'b1;
        csel_n = k_n ? 3'd2 : 3'd1;
        case (state_n)
          RD0:     caddr_rd_n = base_n;
          RD1:     caddr_rd_n = base_n + 12'd1;
          RD2:     caddr_rd_n = base_n + 12'd64;
          default: caddr_rd_n = base_n + 12'd65;
        endcase
      end
      WR_POOL: begin
        cwr_n      = 1'b1;
        caddr_wr_n = {2'b00, p_n};
        cdata_wr_n = max_n;
        csel_n     = k_n ? 3'd4 : 3'd3;
      end
      WR_FLAT: begin
        cwr_n      = 1'b1;
        caddr_wr_n = {1'b0, p_n, k_n};
        cdata_wr_n = max_n;
        csel_n     = 3'd5;
      end
      FIN:     done_n = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      p        <= '0;
      k        <= 1'b0;
      run_max  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= 3'b000;
    end else begin
      state    <= state_n;
      p        <= p_n;
      k        <= k_n;
      run_max  <= max_n;
      busy     <= busy_n;
      done     <= done_n;
      crd      <= crd_n;
      cwr      <= cwr_n;
      caddr_rd <= caddr_rd_n;
      caddr_wr <= caddr_wr_n;
      cdata_wr <= cdata_wr_n;
      csel     <= csel_n;
    end
  end

endmodule

// File: tb/tb_pool_flat_engine.sv
// Directed bench for pool_flat_engine: banked memory model, full passes,
// signed/tie windows, ignored start, mid-pass reset and protocol monitors.
module tb_pool_flat_engine;
  localparam int DW = 20;
  localparam int PASS_CYC = 14337;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, crd, cwr;
  logic [11:0]   caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pool_flat_engine #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  // Banks 1..5; one-cycle read latency. Refills happen in the same block on request.
  logic signed [DW-1:0] mem [1:5][0:4095];
  logic fill_req = 1'b0;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int a = 0; a < 4096; a++) begin
        mem[1][a] = DW'(a);
        mem[2][a] = '0;
        mem[3][a] = 20'h5A5A5;
        mem[4][a] = 20'h5A5A5;
        mem[5][a] = 20'h5A5A5;
      end
      mem[2][0] = 7;   mem[2][1] = 3;   mem[2][64] = 9;   mem[2][65] = 2;
      mem[2][2] = 16;  mem[2][3] = 16;  mem[2][66] = 16;  mem[2][67] = 16;
      mem[2][4] = -5;  mem[2][5] = -1;  mem[2][68] = -8;  mem[2][69] = -3;
      mem[2][6] = -3;  mem[2][7] = 2;   mem[2][70] = -7;  mem[2][71] = 1;
    end
    if (crd && csel >= 3'd1 && csel <= 3'd5) cdata_rd <= mem[csel][caddr_rd];
    if (cwr && csel >= 3'd1 && csel <= 3'd5) mem[csel][caddr_wr] = cdata_wr;
  end

  // Protocol monitor plus write log.
  int viol = 0, done_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  logic done_q = 1'b0;
  logic [34:0] wr_log [0:16383];

  always @(negedge clk) begin
    if (crd && cwr) viol++;
    if (!crd && !cwr && csel != 3'b000) viol++;
    if (!busy && (crd || cwr || done)) viol++;
    if (done && done_q) viol++;
    done_q = done;
    if (done) done_cnt++;
    if (crd) rd_cnt++;
    if (cwr) begin
      if (wr_cnt < 16384) wr_log[wr_cnt] = {csel, caddr_wr, cdata_wr};
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic refill();
    @(posedge clk); #1 fill_req = 1'b1;
    @(posedge clk); #1 fill_req = 1'b0;
  endtask

  task automatic run_pass(input bit extra_start, output int cycles);
    int busy_drop;
    busy_drop = 0;
    cycles = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); cycles++; #1;
      if (cycles == 1) start = 1'b0;
      if (extra_start && cycles == 500) start = 1'b1;
      if (extra_start && cycles == 501) start = 1'b0;
      if (done) break;
      if (!busy) busy_drop++;
    end
    start = 1'b0;
    check("busy_in_pass", busy_drop, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_fin", busy, 0);
  endtask

  // Independent reference: maximum of each 2x2 window, compared against both output layouts.
  task automatic score(output int bad);
    logic signed [DW-1:0] m;
    int b;
    bad = 0;
    for (int kk = 0; kk < 2; kk++)
      for (int pp = 0; pp < 1024; pp++) begin
        b = (pp / 32) * 128 + (pp % 32) * 2;
        m = mem[kk+1][b];
        if (mem[kk+1][b+1]  > m) m = mem[kk+1][b+1];
        if (mem[kk+1][b+64] > m) m = mem[kk+1][b+64];
        if (mem[kk+1][b+65] > m) m = mem[kk+1][b+65];
        if (mem[3+kk][pp] !== m) bad++;
        if (mem[5][pp*2+kk] !== m) bad++;
      end
  endtask

  initial begin
    int cyc, bad, b1, b2, dc, rc, wc, diff;
    bit found;
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {crd, cwr}, 0);
    check("rst_bus", {caddr_rd, caddr_wr, cdata_wr, csel}, 0);
    start = 1'b0;
    reset = 1'b0;

    // Plain pass: bank 1 holds its own address.
    refill();
    b1 = wr_cnt; dc = done_cnt;
    run_pass(1'b0, cyc);
    check("done_latency", cyc, PASS_CYC);
    check("done_count", done_cnt - dc, 1);
    check("L1_0", mem[3][0], 65);
    check("L2_0", mem[5][0], 65);
    check("L1_1023", mem[3][1023], 4095);
    check("L2_2046", mem[5][2046], 4095);
    check("k1_L1_0", mem[4][0], 9);
    check("k1_L2_1", mem[5][1], 9);
    check("equal_L1", mem[4][1], 16);
    check("equal_L2", mem[5][3], 16);
    check("neg_L1", mem[4][2], -1);
    check("neg_L2", mem[5][5], -1);
    check("mixed_sign_L1", mem[4][3], 2);
    check("mixed_sign_L2", mem[5][7], 2);
    score(bad);
    check("score_pass1", bad, 0);
    check("writes_pass1", wr_cnt - b1, 4096);

    // Same pass with a stray start mid-way.
    refill();
    b2 = wr_cnt;
    run_pass(1'b1, cyc);
    check("done_latency_restart_pulse", cyc, PASS_CYC);
    check("writes_pass2", wr_cnt - b2, 4096);
    diff = 0;
    for (int i = 0; i < 4096; i++)
      if (wr_log[b1+i] !== wr_log[b2+i]) diff++;
    check("write_seq_same", diff, 0);

    // Reset during RD2 of p=10 (k=0): B=20, third read at 84.
    refill();
    found = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (crd && caddr_rd == 12'd84 && csel == 3'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("found_rd2_p10", found, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_outs", {done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}, 0);
    dc = done_cnt; rc = rd_cnt; wc = wr_cnt;
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abandon_no_rd", rd_cnt - rc, 0);
    check("abandon_no_wr", wr_cnt - wc, 0);
    check("abandon_no_done", done_cnt - dc, 0);
    refill();
    wc = wr_cnt;
    run_pass(1'b0, cyc);
    check("done_latency_after_rst", cyc, PASS_CYC);
    check("first_wr_after_rst", wr_log[wc], {3'd3, 12'd0, 20'd65});
    score(bad);
    check("score_after_rst", bad, 0);

    check("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_flat_engine.md
POOL_FLAT_ENGINE -- requirements
Module: pool_flat_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 20, giving the width of data words in the conv/pool/flat memories.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset; synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request from the controller to begin pooling and flattening.
REQ-005 The block SHALL have port busy, output, 1 bit: high while a pooling/flatten pass is in progress.
REQ-006 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the pass completes.
REQ-007 The block SHALL have port crd, output, 1 bit: the memory read strobe.
REQ-008 The block SHALL have port caddr_rd, output, 12 bits: the memory read address.
REQ-009 The block SHALL have port cdata_rd, input, DATA_W bits: the memory read data, signed.
REQ-010 The block SHALL have port cwr, output, 1 bit: the memory write strobe.
REQ-011 The block SHALL have port caddr_wr, output, 12 bits: the memory write address.
REQ-012 The block SHALL have port cdata_wr, output, DATA_W bits: the memory write data.
REQ-013 The block SHALL have port csel, output, 3 bits: the memory bank select (001/010 = conv L0 kernel 0/1; 011/100 = pool L1 kernel 0/1; 101 = flat L2).

Function
REQ-014 Memory read latency SHALL be one cycle: cdata_rd in cycle t+1 is the word addressed by caddr_rd/csel with crd=1 in cycle t.
REQ-015 The block SHALL have the states IDLE, RD0, RD1, RD2, RD3, CMP, WR_POOL, WR_FLAT and FIN.
REQ-016 In IDLE, start=1 SHALL clear the pool index p (10 bits, {py[4:0],px[4:0]}) and the kernel bit k, and SHALL move to RD0; start SHALL be ignored in every other state.
REQ-017 The window base address SHALL be B = {py,1'b0,px,1'b0}; RD0..RD3 SHALL issue crd=1 with caddr_rd = B, B+1, B+64, B+65 in that order, csel = k+1.
REQ-018 RD1 SHALL load the running max with cdata_rd; RD2, RD3 and CMP SHALL each replace the max when cdata_rd > max (signed compare; on a tie the max is kept).
REQ-019 CMP SHALL have crd=0, cwr=0 and csel=000.
REQ-020 WR_POOL SHALL drive cwr=1, caddr_wr={2'b00,p}, cdata_wr=max and csel=3+k.
REQ-021 WR_FLAT SHALL drive cwr=1, caddr_wr={1'b0,p,k}, cdata_wr=max and csel=101.
REQ-022 After WR_FLAT, if k=0 the block SHALL set k=1 and go to RD0; else it SHALL set k=0.
REQ-023 After WR_FLAT with k=1, if p=1023 the block SHALL go to FIN; otherwise it SHALL increment p and go to RD0.
REQ-024 Each (p,k) SHALL take exactly 7 cycles; a full pass SHALL take 2048×7 = 14336 cycles from RD0 entry to FIN entry.
REQ-025 FIN SHALL assert done=1 for one cycle and return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 crd and cwr SHALL never be 1 in the same cycle.
REQ-028 Whenever crd=0 and cwr=0, csel SHALL be 000.
REQ-029 No address arithmetic SHALL wrap: B+65 ≤ 4095 for all p, with the maximum at p=1023, B=4030, giving 4095.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE with p=0, k=0 and max=0.
REQ-031 While in reset, every output (busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel) SHALL be 0.
REQ-032 reset SHALL take priority over start in the same cycle.
REQ-033 A reset mid-pass SHALL abandon the pass with no further reads or writes and no done pulse; a subsequent start SHALL restart from p=0, k=0.

Verification
REQ-034 The bench SHALL cover: L0 bank 1 filled with addr value, start -> L1[0] = 65, L2[0] = 65, L1[1023] = 4095, L2[2046] = 4095; done pulses exactly 14337 cycles after start.
REQ-035 The bench SHALL cover: window p=0 k=1 holding {7,3,9,2} at addresses 0,1,64,65 -> L1 bank 4 addr 0 = 9, L2 addr 1 = 9.
REQ-036 The bench SHALL cover: window with all values equal to 0x00010 -> pooled 0x00010; window {-5,-1,-8,-3} (signed) -> pooled -1.
REQ-037 The bench SHALL cover: start pulsed again at cycle 500 of a pass -> no effect; the write sequence is identical to the unperturbed run.
REQ-038 The bench SHALL cover: reset asserted during RD2 of p=10 -> next cycle all outputs 0, busy=0; restart yields a full correct pass.
REQ-039 The bench SHALL cover: assertion checks throughout all runs -> crd&cwr never 1, done width is 1 cycle, busy=0 only in IDLE.
